// File: rtl/pmem_arbiter_if.sv
// Shared pmem port bundle: icache (A), dcache (B) and pmem sides.
// The slave modport is the arbiter's view; master is the environment's.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  pmem_read_a;
  logic [ADDR_WIDTH-1:0] pmem_address_a;
  logic                  pmem_resp_a;
  logic                  pmem_error_a;

  logic                  pmem_read_b;
  logic                  pmem_write_b;
  logic [ADDR_WIDTH-1:0] pmem_address_b;
  logic [LINE_WIDTH-1:0] pmem_wdata_b;
  logic                  pmem_resp_b;
  logic                  pmem_error_b;

  logic [LINE_WIDTH-1:0] cache_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic                  pmem_error;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  modport slave (
    input  pmem_read_a, pmem_address_a,
    input  pmem_read_b, pmem_write_b,
    input  pmem_address_b, pmem_wdata_b,
    input  pmem_resp, pmem_error, pmem_rdata,
    output pmem_resp_a, pmem_error_a,
    output pmem_resp_b, pmem_error_b,
    output cache_rdata,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata
  );

  modport master (
    output pmem_read_a, pmem_address_a,
    output pmem_read_b, pmem_write_b,
    output pmem_address_b, pmem_wdata_b,
    output pmem_resp, pmem_error, pmem_rdata,
    input  pmem_resp_a, pmem_error_a,
    input  pmem_resp_b, pmem_error_b,
    input  cache_rdata,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// icache/dcache arbiter for one pmem port; fixed dcache priority on ties,
// round-robin tie-break when PMEM_ARB_RR_EN is defined.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic          clk,
  input logic          rst,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic                  rd_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic req_a;
  logic req_b;
  logic pick_b;
  logic fin;

  assign req_a = bus.pmem_read_a;
  assign req_b = bus.pmem_read_b | bus.pmem_write_b;
  assign fin   = bus.pmem_resp | bus.pmem_error;

`ifdef PMEM_ARB_RR_EN
  logic last_b;
  assign pick_b = req_b & (~req_a | ~last_b);
`else
  assign pick_b = req_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PMEM_ARB_RR_EN
      last_b  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_a | req_b) begin
`ifdef PMEM_ARB_RR_EN
            last_b <= pick_b;
`endif
            if (pick_b) begin
              state   <= GRANT_B;
              addr_q  <= bus.pmem_address_b;
              wdata_q <= bus.pmem_wdata_b;
              wr_q    <= bus.pmem_write_b;
              rd_q    <= ~bus.pmem_write_b;
            end else begin
              state  <= GRANT_A;
              addr_q <= bus.pmem_address_a;
              wr_q   <= 1'b0;
              rd_q   <= 1'b1;
            end
          end
        end
        GRANT_A, GRANT_B: begin
          if (fin) begin
            state <= DONE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Completion is forwarded in the same cycle pmem reports it.
  assign bus.pmem_resp_a  = (state == GRANT_A) & bus.pmem_resp;
  assign bus.pmem_error_a = (state == GRANT_A) & bus.pmem_error;
  assign bus.pmem_resp_b  = (state == GRANT_B) & bus.pmem_resp;
  assign bus.pmem_error_b = (state == GRANT_B) & bus.pmem_error;

  assign bus.cache_rdata  = bus.pmem_rdata;
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter against a transaction-level model.
// Works in both fixed-priority and PMEM_ARB_RR_EN builds.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit model_last_b = 1'b0;
  logic [LW-1:0] model_wdata = '0;

  function automatic bit model_pick_b(bit ra, bit rb);
    if (!rb) return 1'b0;
    if (!ra) return 1'b1;
`ifdef PMEM_ARB_RR_EN
    return !model_last_b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pmem_read_a    = 1'b0;
    bus.pmem_address_a = '0;
    bus.pmem_read_b    = 1'b0;
    bus.pmem_write_b   = 1'b0;
    bus.pmem_address_b = '0;
    bus.pmem_wdata_b   = '0;
    bus.pmem_resp      = 1'b0;
    bus.pmem_error     = 1'b0;
    bus.pmem_rdata     = '0;
  endtask

  // One full transfer from an IDLE cycle: request, k GRANT cycles, DONE.
  task automatic do_xfer(input bit ra, input bit rbr, input bit rbw,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [LW-1:0] wd, input logic [LW-1:0] rdat,
                         input int lat, input bit rs, input bit er,
                         input string tag);
    bit exp_b;
    bit exp_wr;
    logic [AW-1:0] exp_addr;
    logic [1:0] cmd_exp;
    logic [3:0] rsp_exp;
    exp_b = model_pick_b(ra, rbr | rbw);
    exp_wr = exp_b & rbw;
    exp_addr = exp_b ? ab : aa;
    bus.pmem_read_a    = ra;
    bus.pmem_address_a = aa;
    bus.pmem_read_b    = rbr;
    bus.pmem_write_b   = rbw;
    bus.pmem_address_b = ab;
    bus.pmem_wdata_b   = wd;
    cyc();
    model_last_b = exp_b;
    if (exp_b) model_wdata = wd;
    cmd_exp = {!exp_wr, exp_wr};
    for (int i = 0; i < lat; i++) begin
      if (i > 0) begin
        bus.pmem_address_a = $urandom;
        bus.pmem_address_b = $urandom;
        bus.pmem_wdata_b   = rnd_line();
      end
      rsp_exp = 4'b0000;
      if (i == lat - 1) begin
        bus.pmem_rdata = rdat;
        bus.pmem_resp  = rs;
        bus.pmem_error = er;
        rsp_exp = exp_b ? {2'b00, rs, er} : {rs, er, 2'b00};
      end
      #1;
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== cmd_exp) begin
        errors++;
        $display("FAIL %s cmd cyc%0d got %b exp %b", tag, i,
                 {bus.pmem_read, bus.pmem_write}, cmd_exp);
      end
      checks++;
      if (bus.pmem_address !== exp_addr) begin
        errors++;
        $display("FAIL %s addr got %h exp %h", tag, bus.pmem_address,
                 exp_addr);
      end
      checks++;
      if (bus.pmem_wdata !== model_wdata) begin
        errors++;
        $display("FAIL %s wdata got %h exp %h", tag, bus.pmem_wdata,
                 model_wdata);
      end
      checks++;
      if ({bus.pmem_resp_a, bus.pmem_error_a, bus.pmem_resp_b,
           bus.pmem_error_b} !== rsp_exp) begin
        errors++;
        $display("FAIL %s resp cyc%0d got %b exp %b", tag, i,
                 {bus.pmem_resp_a, bus.pmem_error_a, bus.pmem_resp_b,
                  bus.pmem_error_b}, rsp_exp);
      end
      if (i == lat - 1) begin
        checks++;
        if (bus.cache_rdata !== rdat) begin
          errors++;
          $display("FAIL %s rdata got %h exp %h", tag, bus.cache_rdata,
                   rdat);
        end
      end
      cyc();
    end
    bus.pmem_resp   = 1'b0;
    bus.pmem_error  = 1'b0;
    bus.pmem_read_a = 1'b0;
    bus.pmem_read_b = 1'b0;
    bus.pmem_write_b = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_resp_a, bus.pmem_error_a,
         bus.pmem_resp_b, bus.pmem_error_b} !== 6'b0) begin
      errors++;
      $display("FAIL %s done got %b exp 000000", tag,
               {bus.pmem_read, bus.pmem_write, bus.pmem_resp_a,
                bus.pmem_error_a, bus.pmem_resp_b, bus.pmem_error_b});
    end
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_resp_a, bus.pmem_error_a,
         bus.pmem_resp_b, bus.pmem_error_b} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {bus.pmem_read, bus.pmem_write, bus.pmem_resp_a,
                bus.pmem_error_a, bus.pmem_resp_b, bus.pmem_error_b});
    end
    checks++;
    if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0", bus.pmem_address,
               bus.pmem_wdata);
    end
    rst = 1'b0;
    model_last_b = 1'b0;
    model_wdata = '0;
    cyc();
  endtask

  task automatic test_lone_a();
    logic [LW-1:0] a5;
    a5 = {(LW / 8){8'hA5}};
    do_xfer(1, 0, 0, 32'h0000_1040, '0, '0, a5, 3, 1, 0, "lone_a");
  endtask

  task automatic test_lone_b_write();
    logic [LW-1:0] w;
    w = {(LW / 32){32'h1234_5678}};
    do_xfer(0, 0, 1, '0, 32'h0000_2000, w, rnd_line(), 4, 1, 0, "lone_bw");
  endtask

  task automatic test_tie();
    for (int n = 0; n < 3; n++)
      do_xfer(1, 1, 0, 32'h0000_A000 + n, 32'h0000_B000 + n, rnd_line(),
              rnd_line(), 2, 1, 0, "tie");
  endtask

  task automatic test_error();
    do_xfer(0, 1, 0, '0, 32'h0000_4400, rnd_line(), rnd_line(), 2, 0, 1,
            "err_b");
    do_xfer(0, 1, 1, '0, 32'h0000_4800, rnd_line(), rnd_line(), 1, 1, 1,
            "both_b");
  endtask

  task automatic test_reset_mid_grant();
    bus.pmem_read_a    = 1'b1;
    bus.pmem_address_a = 32'h0000_3000;
    cyc();
    checks++;
    if (bus.pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got %b exp 1", bus.pmem_read);
    end
    #2;
    rst = 1'b1;
    bus.pmem_resp = 1'b1;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_resp_a, bus.pmem_resp_b} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_drop got %b exp 000",
               {bus.pmem_read, bus.pmem_resp_a, bus.pmem_resp_b});
    end
    bus.pmem_resp = 1'b0;
    #1;
    rst = 1'b0;
    model_last_b = 1'b0;
    model_wdata = '0;
    do_xfer(1, 0, 0, 32'h0000_3000, '0, '0, rnd_line(), 2, 1, 0, "rstmid");
  endtask

  task automatic test_no_regrant();
    do_xfer(1, 0, 0, 32'h0000_5000, '0, '0, rnd_line(), 1, 1, 0, "held");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
        errors++;
        $display("FAIL regrant cyc%0d got %b exp 00", i,
                 {bus.pmem_read, bus.pmem_write});
      end
      cyc();
    end
  endtask

  task automatic test_random();
    bit ra, rbr, rbw, er, rs;
    for (int n = 0; n < 30; n++) begin
      ra  = $urandom_range(0, 1);
      rbr = $urandom_range(0, 1);
      rbw = $urandom_range(0, 1);
      if (!(ra | rbr | rbw)) ra = 1'b1;
      er = ($urandom_range(0, 5) == 0);
      rs = er ? 1'($urandom_range(0, 1)) : 1'b1;
      do_xfer(ra, rbr, rbw, $urandom, $urandom, rnd_line(), rnd_line(),
              $urandom_range(1, 4), rs, er, "rand");
      if ($urandom_range(0, 3) == 0) begin
        checks++;
        if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
          errors++;
          $display("FAIL rand_idle got %b exp 00",
                   {bus.pmem_read, bus.pmem_write});
        end
        cyc();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lone_a();
    test_lone_b_write();
    test_tie();
    test_error();
    test_reset_mid_grant();
    test_no_regrant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
